axi_lite_line_master: RTL and testbench
=======================================

# axi_lite_line_master

Converts one cache-line request from `cache_fsm` into a sequence of single-word AXI4-Lite transactions, and signals completion back to it. It sits directly downstream of `cache_fsm`: it consumes `read_start_i`, `read_start_d` and `write_start`, returns `axi_done`, delivers the fetched line to the I/D caches, and takes the dirty line for write-back. It is the only AXI4-Lite master on the cache side of the core.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: AXI address width.
- `WORD_WIDTH`, 32: AXI data width; also the cache word width.
- `BLOCK_WIDTH`, 512: cache line width. `WORD_COUNT = BLOCK_WIDTH/WORD_WIDTH` must be a power of two, ≥2.

Ports:
- `i_clk`  in  1  clock.
- `i_arst`  in  1  reset; asynchronous, active-high.
- `i_read_start_i`, `i_read_start_d`, `i_write_start`  in  1 each  level requests from `cache_fsm`.
- `i_addr_i`, `i_addr_d`, `i_addr_wb`  in  ADDR_WIDTH each  line addresses for the I-fetch, D-fetch and write-back.
- `i_wb_line`  in  BLOCK_WIDTH  dirty line to write back.
- `o_line`  out  BLOCK_WIDTH  assembled read line; word k is at bits [k*WORD_WIDTH +: WORD_WIDTH].
- `o_done`  out  1  one-cycle completion pulse; drives `cache_fsm` `i_axi_done`.
- `o_axi_err`  out  1  valid with `o_done`; high if any beat returned a non-OKAY response.
- AXI AW: `o_awaddr`  out  ADDR_WIDTH; `o_awvalid`  out  1; `i_awready`  in  1.
- AXI W: `o_wdata`  out  WORD_WIDTH; `o_wstrb`  out  WORD_WIDTH/8; `o_wvalid`  out  1; `i_wready`  in  1.
- AXI B: `i_bresp`  in  2; `i_bvalid`  in  1; `o_bready`  out  1.
- AXI AR: `o_araddr`  out  ADDR_WIDTH; `o_arvalid`  out  1; `i_arready`  in  1.
- AXI R: `i_rdata`  in  WORD_WIDTH; `i_rresp`  in  2; `i_rvalid`  in  1; `o_rready`  out  1.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- Start in IDLE. If `i_write_start`, latch `i_addr_wb` and `i_wb_line`, then go to WR_REQ. Otherwise, if `i_read_start_d`, latch `i_addr_d`, then go to RD_ADDR. Otherwise, if `i_read_start_i`, latch `i_addr_i`, then go to RD_ADDR.
  - Priority is write > read_d > read_i.
  - On start: clear the word counter `cnt` and the sticky error flag.
- Starts are ignored outside IDLE.
- Base address is the latched address with its low log2(BLOCK_WIDTH/8) bits forced to 0. Beat address is `base + cnt*(WORD_WIDTH/8)`.
- RD_ADDR: `o_arvalid`=1.
  - On `i_arready`, go to RD_DATA.
- RD_DATA: `o_rready`=1.
  - On `i_rvalid`, store `i_rdata` into word `cnt` of the line register. OR `(i_rresp != OKAY)` into the error flag.
  - If `cnt == WORD_COUNT-1`, go to DONE; otherwise increment `cnt` and go to RD_ADDR.
- WR_REQ: `o_awvalid` and `o_wvalid` assert together.
  - Each valid drops independently after its own handshake; two flags track "AW sent" and "W sent".
  - When both have completed, go to WR_RESP. Both may complete in the same cycle.
  - `o_wdata` = word `cnt` of the latched line. `o_wstrb` = all ones.
- WR_RESP: `o_bready`=1.
  - On `i_bvalid`, OR the `i_bresp` error into the flag.
  - Last beat goes to DONE; otherwise increment `cnt` and go to WR_REQ.
- DONE: `o_done`=1 and `o_axi_err` = flag for exactly one cycle, then IDLE. `o_line` holds its value until the next read's first R beat.
- Only one transaction is ever outstanding. An error response does not abort the line.

## Timing
- Reset value of every output is 0: all valids, readies, `o_done`, `o_axi_err`, the address/data buses, and `o_line`. `cnt`=0 and state=IDLE.
- Reset mid-transaction aborts immediately; AXI valids drop asynchronously.
- All AXI outputs and `o_done` are registered or decoded from state only. No valid depends combinationally on a ready.
- The first AR/AW is asserted the cycle after a start is seen in IDLE.
- Zero-wait slave timing:
  - Read line: 2·WORD_COUNT cycles + 1 DONE cycle (33 at defaults).
  - Write line: 2·WORD_COUNT + 1.
- DONE → IDLE lets `cache_fsm`'s held-high start (still asserted during the DONE cycle) be ignored.
- A WRITE_BACK→ALLOCATE_D follow-on read_start_d is accepted in the IDLE cycle after DONE.
- Address and data stay stable while valid is high and ready is low.

## Structure
- Shared package `cache_pkg`:
  - `BLOCK_WIDTH`, `WORD_WIDTH`, `WORD_COUNT` and the AXI resp constants (OKAY=2'b00, SLVERR=2'b10).
  - The `t_axi_state` enum.
- No sub-module. The counter, line register and FSM are inline.

## Test plan
- read_start_d, addr 0x1000_0024, zero-wait slave returning word k = 0xA000_0000+k → araddr sequence 0x1000_0000…0x1000_003C. `o_done` at cycle 33, with `o_line` word 15 = 0xA000_000F and `o_axi_err`=0.
- write_start with line words k = k, awready delayed 3 cycles and wready immediate → valids drop independently. 16 B handshakes, wdata 0..15, wstrb=4'hF. One `o_done` pulse.
- write_start then read_start_d the cycle after DONE (WRITE_BACK→ALLOCATE_D) → read begins without a lost cycle. No second write is issued while start is still held during DONE.
- read_start_i and read_start_d both high → the D address is used. read_start_i held through DONE → exactly one pulse, no relaunch.
- Beat 5 rresp=SLVERR → all 16 beats complete and `o_axi_err`=1 with `o_done`. The next clean line reports 0.
- `i_arst` during beat 7 of a read → all outputs 0 the same cycle. After release, a fresh request restarts at word 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache-side definitions: line geometry, AXI response codes and the
// line-master state type.
package cache_pkg;

  localparam int unsigned BLOCK_WIDTH = 512;
  localparam int unsigned WORD_WIDTH  = 32;
  localparam int unsigned WORD_COUNT  = BLOCK_WIDTH / WORD_WIDTH;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_DONE
  } t_axi_state;

endpackage

// File: rtl/axi_lite_line_master.sv
// Turns one cache-line fetch or write-back into a series of single-word
// AXI4-Lite beats and pulses o_done once the whole line has been moved.
module axi_lite_line_master #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned WORD_WIDTH  = cache_pkg::WORD_WIDTH,
  parameter int unsigned BLOCK_WIDTH = cache_pkg::BLOCK_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_arst,
  input  logic                    i_read_start_i,
  input  logic                    i_read_start_d,
  input  logic                    i_write_start,
  input  logic [ADDR_WIDTH-1:0]   i_addr_i,
  input  logic [ADDR_WIDTH-1:0]   i_addr_d,
  input  logic [ADDR_WIDTH-1:0]   i_addr_wb,
  input  logic [BLOCK_WIDTH-1:0]  i_wb_line,
  output logic [BLOCK_WIDTH-1:0]  o_line,
  output logic                    o_done,
  output logic                    o_axi_err,
  output logic [ADDR_WIDTH-1:0]   o_awaddr,
  output logic                    o_awvalid,
  input  logic                    i_awready,
  output logic [WORD_WIDTH-1:0]   o_wdata,
  output logic [WORD_WIDTH/8-1:0] o_wstrb,
  output logic                    o_wvalid,
  input  logic                    i_wready,
  input  logic [1:0]              i_bresp,
  input  logic                    i_bvalid,
  output logic                    o_bready,
  output logic [ADDR_WIDTH-1:0]   o_araddr,
  output logic                    o_arvalid,
  input  logic                    i_arready,
  input  logic [WORD_WIDTH-1:0]   i_rdata,
  input  logic [1:0]              i_rresp,
  input  logic                    i_rvalid,
  output logic                    o_rready
);

  import cache_pkg::t_axi_state;
  import cache_pkg::ST_IDLE;
  import cache_pkg::ST_RD_ADDR;
  import cache_pkg::ST_RD_DATA;
  import cache_pkg::ST_WR_REQ;
  import cache_pkg::ST_WR_RESP;
  import cache_pkg::ST_DONE;
  import cache_pkg::AXI_OKAY;

  localparam int unsigned WORD_COUNT = BLOCK_WIDTH / WORD_WIDTH;
  localparam int unsigned CNT_W      = $clog2(WORD_COUNT);
  localparam int unsigned BYTE_SH    = $clog2(WORD_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(BLOCK_WIDTH / 8 - 1);

  t_axi_state              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   beat_addr;
  logic [BLOCK_WIDTH-1:0]  wb_line_q;
  logic                    err_q;
  logic                    aw_sent_q, w_sent_q;
  logic                    last_beat;
  logic                    aw_done, w_done;

  assign last_beat = (cnt_q == CNT_W'(WORD_COUNT - 1));
  assign beat_addr = (addr_q & ~LINE_MASK) + (ADDR_WIDTH'(cnt_q) << BYTE_SH);

  // Valids are !sent while in WR_REQ, so "done" reduces to sent-or-ready.
  assign aw_done = aw_sent_q | i_awready;
  assign w_done  = w_sent_q  | i_wready;

  assign o_arvalid = (state_q == ST_RD_ADDR);
  assign o_rready  = (state_q == ST_RD_DATA);
  assign o_awvalid = (state_q == ST_WR_REQ) && !aw_sent_q;
  assign o_wvalid  = (state_q == ST_WR_REQ) && !w_sent_q;
  assign o_bready  = (state_q == ST_WR_RESP);
  assign o_done    = (state_q == ST_DONE);
  assign o_axi_err = (state_q == ST_DONE) && err_q;
  assign o_araddr  = beat_addr;
  assign o_awaddr  = beat_addr;
  assign o_wdata   = wb_line_q[cnt_q*WORD_WIDTH +: WORD_WIDTH];
  assign o_wstrb   = (state_q == ST_WR_REQ) ? '1 : '0;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_write_start)                        state_d = ST_WR_REQ;
        else if (i_read_start_d || i_read_start_i) state_d = ST_RD_ADDR;
      end
      ST_RD_ADDR: if (i_arready) state_d = ST_RD_DATA;
      ST_RD_DATA: if (i_rvalid)  state_d = last_beat ? ST_DONE : ST_RD_ADDR;
      ST_WR_REQ:  if (aw_done && w_done) state_d = ST_WR_RESP;
      ST_WR_RESP: if (i_bvalid)  state_d = last_beat ? ST_DONE : ST_WR_REQ;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      cnt_q     <= '0;
      addr_q    <= '0;
      wb_line_q <= '0;
      err_q     <= 1'b0;
      aw_sent_q <= 1'b0;
      w_sent_q  <= 1'b0;
      o_line    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          aw_sent_q <= 1'b0;
          w_sent_q  <= 1'b0;
          if (i_write_start || i_read_start_d || i_read_start_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
          end
          if (i_write_start) begin
            addr_q    <= i_addr_wb;
            wb_line_q <= i_wb_line;
          end else if (i_read_start_d) begin
            addr_q <= i_addr_d;
          end else if (i_read_start_i) begin
            addr_q <= i_addr_i;
          end
        end
        ST_RD_DATA: if (i_rvalid) begin
          o_line[cnt_q*WORD_WIDTH +: WORD_WIDTH] <= i_rdata;
          err_q <= err_q | (i_rresp != AXI_OKAY);
          if (!last_beat) cnt_q <= cnt_q + 1'b1;
        end
        ST_WR_REQ: begin
          if (aw_done && w_done) begin
            aw_sent_q <= 1'b0;
            w_sent_q  <= 1'b0;
          end else begin
            aw_sent_q <= aw_done;
            w_sent_q  <= w_done;
          end
        end
        ST_WR_RESP: if (i_bvalid) begin
          err_q <= err_q | (i_bresp != AXI_OKAY);
          if (!last_beat) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_line_master.sv
// Directed + randomized bench for axi_lite_line_master with a single-process
// AXI4-Lite slave driven on the falling edge.
module tb_axi_lite_line_master;

  localparam int WC = 16;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic         clk = 1'b0;
  logic         arst;
  logic         rs_i, rs_d, ws;
  logic [31:0]  a_i, a_d, a_wb;
  logic [511:0] wb_line, line;
  logic         done, axi_err;
  logic [31:0]  awaddr, wdata, araddr, rdata;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;

  always #5 clk = ~clk;

  axi_lite_line_master #(.ADDR_WIDTH(32), .WORD_WIDTH(32), .BLOCK_WIDTH(512)) dut (
    .i_clk(clk), .i_arst(arst),
    .i_read_start_i(rs_i), .i_read_start_d(rs_d), .i_write_start(ws),
    .i_addr_i(a_i), .i_addr_d(a_d), .i_addr_wb(a_wb), .i_wb_line(wb_line),
    .o_line(line), .o_done(done), .o_axi_err(axi_err),
    .o_awaddr(awaddr), .o_awvalid(awvalid), .i_awready(awready),
    .o_wdata(wdata), .o_wstrb(wstrb), .o_wvalid(wvalid), .i_wready(wready),
    .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready),
    .o_araddr(araddr), .o_arvalid(arvalid), .i_arready(arready),
    .i_rdata(rdata), .i_rresp(rresp), .i_rvalid(rvalid), .o_rready(rready)
  );

  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [31:0] words [WC];
  logic [31:0] ar_q[$], aw_q[$], wd_q[$];
  logic [3:0]  ws_q[$];
  int ar_wait, r_wait, aw_wait, w_wait, b_wait;
  int aw_n, w_n, b_n, r_beats, rerr_beat, berr_beat;
  int ar_fix = -1, aw_fix = -1, dmax = 0;
  int done_n = 0, done_base, done_cyc, start_cyc, first_ar_cyc;
  logic done_err;
  bit rd_pend, indep_seen, ar_st, aw_st, w_st;
  logic [31:0] rd_addr, ar_prev, aw_prev, w_prev;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int fix);
    return (fix >= 0) ? fix : int'($urandom_range(dmax, 0));
  endfunction

  task automatic slave_clear();
    ar_q.delete(); aw_q.delete(); wd_q.delete(); ws_q.delete();
    ar_wait = -1; r_wait = -1; aw_wait = -1; w_wait = -1; b_wait = -1;
    aw_n = 0; w_n = 0; b_n = 0; r_beats = 0; rd_pend = 0;
    indep_seen = 0; ar_st = 0; aw_st = 0; w_st = 0; first_ar_cyc = -1;
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    rdata = '0; rresp = OKAY; bresp = OKAY;
  endtask

  // One clock: observe DUT at the falling edge, then drive slave responses.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (ar_st) chk("ar_hold", {arvalid, araddr}, {1'b1, ar_prev});
    if (aw_st) chk("aw_hold", {awvalid, awaddr}, {1'b1, aw_prev});
    if (w_st)  chk("w_hold",  {wvalid, wdata},   {1'b1, w_prev});
    rvalid = 0; rdata = '0; rresp = OKAY;
    if (rd_pend) begin
      if (r_wait > 0) r_wait--;
      else begin
        rvalid = 1;
        rdata  = words[rd_addr[5:2]];
        rresp  = (r_beats == rerr_beat) ? SLVERR : OKAY;
        if (rready) begin rd_pend = 0; r_beats++; end
      end
    end
    bvalid = 0; bresp = OKAY;
    if (b_n < aw_n && b_n < w_n) begin
      if (b_wait < 0) b_wait = pick(-1);
      if (b_wait > 0) b_wait--;
      else begin
        bvalid = 1;
        bresp  = (b_n == berr_beat) ? SLVERR : OKAY;
        if (bready) begin b_n++; b_wait = -1; end
      end
    end
    arready = 0;
    if (arvalid) begin
      if (first_ar_cyc < 0) first_ar_cyc = cyc;
      if (ar_wait < 0) ar_wait = pick(ar_fix);
      if (ar_wait == 0) begin
        arready = 1; ar_q.push_back(araddr);
        rd_pend = 1; rd_addr = araddr; r_wait = pick(-1); ar_wait = -1;
      end else ar_wait--;
    end
    awready = 0;
    if (awvalid && !wvalid) indep_seen = 1;
    if (awvalid) begin
      if (aw_wait < 0) aw_wait = pick(aw_fix);
      if (aw_wait == 0) begin
        awready = 1; aw_q.push_back(awaddr); aw_n++; aw_wait = -1;
      end else aw_wait--;
    end
    wready = 0;
    if (wvalid) begin
      if (w_wait < 0) w_wait = pick(-1);
      if (w_wait == 0) begin
        wready = 1; wd_q.push_back(wdata); ws_q.push_back(wstrb); w_n++; w_wait = -1;
      end else w_wait--;
    end
    ar_st = arvalid && !arready; ar_prev = araddr;
    aw_st = awvalid && !awready; aw_prev = awaddr;
    w_st  = wvalid && !wready;   w_prev  = wdata;
    if (done) begin done_n++; done_err = axi_err; done_cyc = cyc; end
  endtask

  // kind: 0 write-back, 1 read_d, 2 read_i, 3 read_i and read_d together
  task automatic launch(input int kind, input logic [31:0] a);
    slave_clear();
    rs_i = 0; rs_d = 0; ws = 0;
    case (kind)
      0: begin
        ws = 1; a_wb = a;
        for (int k = 0; k < WC; k++) wb_line[k*32 +: 32] = words[k];
      end
      1: begin rs_d = 1; a_d = a; end
      2: begin rs_i = 1; a_i = a; end
      default: begin rs_i = 1; rs_d = 1; a_d = a; a_i = a ^ 32'h0100_0000; end
    endcase
    start_cyc = cyc;
    done_base = done_n;
  endtask

  // Waits for o_done, then one more cycle with the start still held.
  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000 && done_n == done_base; i++) step();
    chk({tag, " done_seen"}, done_n - done_base, 1);
    step();
  endtask

  task automatic quiet(input string tag);
    int nar, naw;
    rs_i = 0; rs_d = 0; ws = 0;
    nar = ar_q.size(); naw = aw_q.size();
    repeat (5) step();
    chk({tag, " no_relaunch"}, {ar_q.size() - nar, aw_q.size() - naw}, '0);
    chk({tag, " one_done"}, done_n - done_base, 1);
  endtask

  task automatic check_read(input string tag, input logic [31:0] a, input bit zero);
    logic [31:0]  base;
    logic [511:0] exp;
    base = a & 32'hFFFF_FFC0;
    chk({tag, " ar_count"}, ar_q.size(), WC);
    for (int k = 0; k < WC; k++) begin
      if (k < ar_q.size()) chk($sformatf("%s araddr[%0d]", tag, k), ar_q[k], base + 32'(4*k));
      exp[k*32 +: 32] = words[k];
    end
    chk({tag, " line"}, line, exp);
    chk({tag, " err"}, done_err, (rerr_beat >= 0 && rerr_beat < WC));
    if (zero) chk({tag, " latency"}, done_cyc - start_cyc, 2*WC + 1);
  endtask

  task automatic check_write(input string tag, input logic [31:0] a, input bit zero);
    logic [31:0] base;
    base = a & 32'hFFFF_FFC0;
    chk({tag, " aw_w_b_count"}, {aw_q.size(), wd_q.size(), b_n}, {WC, WC, WC});
    for (int k = 0; k < WC; k++) begin
      if (k < aw_q.size()) chk($sformatf("%s awaddr[%0d]", tag, k), aw_q[k], base + 32'(4*k));
      if (k < wd_q.size()) chk($sformatf("%s wdata[%0d]", tag, k), {ws_q[k], wd_q[k]}, {4'hF, words[k]});
    end
    chk({tag, " err"}, done_err, (berr_beat >= 0 && berr_beat < WC));
    if (zero) chk({tag, " latency"}, done_cyc - start_cyc, 2*WC + 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " ctrl"}, {arvalid, rready, awvalid, wvalid, bready, done, axi_err}, '0);
    chk({tag, " buses"}, {araddr, awaddr, wdata, wstrb}, '0);
    chk({tag, " line"}, line, '0);
  endtask

  initial begin
    int prev_done_cyc, kind, z;
    logic [31:0] a;
    arst = 1; rs_i = 0; rs_d = 0; ws = 0; a_i = '0; a_d = '0; a_wb = '0; wb_line = '0;
    rerr_beat = -1; berr_beat = -1;
    slave_clear();
    repeat (3) step();
    check_all_zero("reset");
    arst = 0;
    step();

    // Zero-wait D-fetch with known pattern
    for (int k = 0; k < WC; k++) words[k] = 32'hA000_0000 + 32'(k);
    launch(1, 32'h1000_0024);
    wait_done("rd_d");
    quiet("rd_d");
    check_read("rd_d", 32'h1000_0024, 1);
    chk("rd_d word15", line[15*32 +: 32], 32'hA000_000F);

    // Write-back with slow AW, then ALLOCATE_D follow-on in the IDLE cycle
    for (int k = 0; k < WC; k++) words[k] = 32'(k);
    aw_fix = 3;
    launch(0, 32'h2000_0100);
    wait_done("wb");
    aw_fix = -1;
    chk("wb indep_valid", indep_seen, 1'b1);
    check_write("wb", 32'h2000_0100, 0);
    prev_done_cyc = done_cyc;
    for (int k = 0; k < WC; k++) words[k] = $urandom;
    launch(1, 32'h3000_0040);
    wait_done("alloc");
    chk("alloc first_ar", first_ar_cyc - prev_done_cyc, 2);
    quiet("alloc");
    chk("alloc no_rewrite", aw_q.size(), 0);
    check_read("alloc", 32'h3000_0040, 1);

    // read_i and read_d together: D address wins, held start yields one pulse
    for (int k = 0; k < WC; k++) words[k] = $urandom;
    launch(3, 32'h4000_1234);
    wait_done("both");
    quiet("both");
    check_read("both", 32'h4000_1234, 1);

    // SLVERR on beat 5, then a clean line
    for (int k = 0; k < WC; k++) words[k] = $urandom;
    rerr_beat = 5;
    launch(1, 32'h5000_0000);
    wait_done("rerr");
    quiet("rerr");
    check_read("rerr", 32'h5000_0000, 1);
    rerr_beat = -1;
    launch(2, 32'h5000_0080);
    wait_done("clean");
    quiet("clean");
    check_read("clean", 32'h5000_0080, 1);

    // Asynchronous reset in the middle of word 7
    launch(1, 32'h6000_0000);
    for (int i = 0; i < 200 && ar_q.size() < 8; i++) step();
    chk("mid ar_reached", ar_q.size(), 8);
    arst = 1;
    #1;
    check_all_zero("mid_rst");
    rs_d = 0;
    slave_clear();
    step();
    arst = 0;
    for (int k = 0; k < WC; k++) words[k] = $urandom;
    launch(1, 32'h7000_01C0);
    wait_done("after_rst");
    quiet("after_rst");
    check_read("after_rst", 32'h7000_01C0, 1);

    // Randomized lines, delays and error responses
    for (int it = 0; it < 8; it++) begin
      kind = int'($urandom_range(3, 0));
      a = $urandom;
      dmax = (it < 2) ? 0 : int'($urandom_range(3, 0));
      z = (dmax == 0);
      for (int k = 0; k < WC; k++) words[k] = $urandom;
      rerr_beat = $urandom_range(1, 0) ? int'($urandom_range(WC-1, 0)) : -1;
      berr_beat = $urandom_range(1, 0) ? int'($urandom_range(WC-1, 0)) : -1;
      launch(kind, a);
      wait_done($sformatf("rnd%0d", it));
      quiet($sformatf("rnd%0d", it));
      if (kind == 0) check_write($sformatf("rnd%0d", it), a, z[0]);
      else           check_read($sformatf("rnd%0d", it), a, z[0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
